// File: rtl/bus3do_pkg.sv
// Shared 3DO bus map: region windows, bridge FSM encoding and default error data.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
package bus3do_pkg;

  localparam logic [31:0] SVF_BASE    = 32'h0320_0000;
  localparam logic [31:0] SVF_LIMIT   = 32'h0320_FFFF;
  localparam logic [31:0] MADAM_BASE  = 32'h0330_0000;
  localparam logic [31:0] MADAM_LIMIT = 32'h0330_FFFF;
  localparam logic [31:0] CLIO_BASE   = 32'h0340_0000;
  localparam logic [31:0] CLIO_LIMIT  = 32'h0340_FFFF;

  // Returned for SVF reads and for external accesses that never completed.
  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hBADA_CCE5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REG_STB  = 3'd1,
    REG_CAP  = 3'd2,
    EXT_WAIT = 3'd3,
    ACK      = 3'd4
  } bus_state_t;

  typedef enum logic [1:0] {
    RGN_EXT   = 2'd0,
    RGN_SVF   = 2'd1,
    RGN_MADAM = 2'd2,
    RGN_CLIO  = 2'd3
  } region_t;

  // Anything outside the three register windows belongs to external memory.
  function automatic region_t decode_region(input logic [31:0] adr);
    if (adr >= SVF_BASE && adr <= SVF_LIMIT)     return RGN_SVF;
    if (adr >= MADAM_BASE && adr <= MADAM_LIMIT) return RGN_MADAM;
    if (adr >= CLIO_BASE && adr <= CLIO_LIMIT)   return RGN_CLIO;
    return RGN_EXT;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// External-wait watchdog: counts stalled EXT_WAIT cycles and flags the one that reaches the limit.
// Latency: expired is combinational in the cycle whose increment would reach TIMEOUT_CYCLES.
// Backpressure: none; load restarts the count for each accepted request.
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Clear on a new request, advance once per stalled wait cycle.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Fires on the stalled cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/cpu_bus_bridge.sv
// Wishbone bridge from the ARM core to SVF/MADAM/CLIO register windows and external memory.
// Latency: SVF ack 1 cycle after accept, register ack 2, external ack 1 cycle after ext_ack or timeout.
// Backpressure: one request at a time, sampled only in IDLE; the external slave stalls by withholding ext_ack.
module cpu_bus_bridge
  import bus3do_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] BAD_DATA       = BAD_DATA_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        i_reset,
  input  logic        cpu_cyc,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdat,
  input  logic [3:0]  cpu_sel,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdat,
  output logic        madam_rd,
  output logic        madam_wr,
  input  logic [31:0] madam_rdat,
  output logic        clio_rd,
  output logic        clio_wr,
  input  logic [31:0] clio_rdat,
  output logic [31:0] reg_adr,
  output logic [31:0] reg_wdat,
  output logic        ext_stb,
  output logic [31:0] ext_adr,
  output logic        ext_we,
  output logic [3:0]  ext_sel,
  output logic [31:0] ext_wdat,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdat,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] err_adr
);

  bus_state_t  state_q, state_d;
  region_t     region_q;
  region_t     region_in;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;

  logic accept;
  logic ext_wait;
  logic ext_done;
  logic tmo_en;
  logic tmo_expired;
  logic tmo_fire;

  assign region_in = decode_region(cpu_adr);
  assign accept    = (state_q == IDLE) && cpu_cyc && cpu_stb;
  assign ext_wait  = (state_q == EXT_WAIT);
  // A dropped cycle beats both completion and timeout.
  assign ext_done  = ext_wait && cpu_cyc && ext_ack;
  assign tmo_en    = ext_wait && !ext_ack;
  assign tmo_fire  = ext_wait && cpu_cyc && !ext_ack && tmo_expired;

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (sys_clk),
    .reset  (i_reset),
    .load   (accept),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: route by decoded region, abort on a dropped cycle, ACK always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (region_in)
            RGN_SVF:            state_d = ACK;
            RGN_MADAM, RGN_CLIO: state_d = REG_STB;
            default:            state_d = EXT_WAIT;
          endcase
        end
      end
      // Slave data is sampled at the end of the strobe cycle, so the capture
      // encoding is only a pass-through to ACK.
      REG_STB:  state_d = cpu_cyc ? ACK : IDLE;
      REG_CAP:  state_d = ACK;
      EXT_WAIT: begin
        if (!cpu_cyc)                   state_d = IDLE;
        else if (ext_ack || tmo_expired) state_d = ACK;
      end
      ACK:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: one register strobe in REG_STB, ext_stb while waiting, ack in ACK.
  always_comb begin
    cpu_ack  = 1'b0;
    madam_rd = 1'b0;
    madam_wr = 1'b0;
    clio_rd  = 1'b0;
    clio_wr  = 1'b0;
    ext_stb  = 1'b0;
    case (state_q)
      REG_STB: begin
        madam_rd = (region_q == RGN_MADAM) && !we_q;
        madam_wr = (region_q == RGN_MADAM) &&  we_q;
        clio_rd  = (region_q == RGN_CLIO)  && !we_q;
        clio_wr  = (region_q == RGN_CLIO)  &&  we_q;
      end
      EXT_WAIT: ext_stb = 1'b1;
      ACK:      cpu_ack = 1'b1;
      default: ;
    endcase
  end

  // Latch the request and its decode when it is accepted.
  always_ff @(posedge sys_clk) begin
    if (i_reset) begin
      region_q <= RGN_EXT;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
    end else if (accept) begin
      region_q <= region_in;
      we_q     <= cpu_we;
      adr_q    <= cpu_adr;
      wdat_q   <= cpu_wdat;
      sel_q    <= cpu_sel;
    end
  end

  assign reg_adr  = adr_q;
  assign reg_wdat = wdat_q;
  assign ext_adr  = adr_q;
  assign ext_we   = we_q;
  assign ext_sel  = sel_q;
  assign ext_wdat = wdat_q;

  // Read data register: loaded on the edge that moves the FSM into ACK.
  always_ff @(posedge sys_clk) begin
    if (i_reset) begin
      cpu_rdat <= '0;
    end else if (accept && region_in == RGN_SVF) begin
      cpu_rdat <= cpu_we ? 32'h0 : BAD_DATA;
    end else if (state_q == REG_STB && cpu_cyc) begin
      if (we_q)                       cpu_rdat <= 32'h0;
      else if (region_q == RGN_MADAM) cpu_rdat <= madam_rdat;
      else                            cpu_rdat <= clio_rdat;
    end else if (ext_done) begin
      cpu_rdat <= ext_rdat;
    end else if (tmo_fire) begin
      cpu_rdat <= BAD_DATA;
    end
  end

  // Sticky timeout flag; err_adr keeps the first offender until the flag is cleared.
  always_ff @(posedge sys_clk) begin
    if (i_reset) begin
      bus_err <= 1'b0;
      err_adr <= '0;
    end else if (tmo_fire) begin
      bus_err <= 1'b1;
      if (!bus_err) err_adr <= adr_q;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
module tb_cpu_bus_bridge;

  localparam int          T   = 8;
  localparam logic [31:0] BAD = 32'hBADACCE5;

  logic        sys_clk = 1'b0;
  logic        i_reset;
  logic        cpu_cyc, cpu_stb, cpu_we;
  logic [31:0] cpu_adr, cpu_wdat;
  logic [3:0]  cpu_sel;
  logic        cpu_ack;
  logic [31:0] cpu_rdat;
  logic        madam_rd, madam_wr, clio_rd, clio_wr;
  logic [31:0] madam_rdat, clio_rdat;
  logic [31:0] reg_adr, reg_wdat;
  logic        ext_stb, ext_we;
  logic [31:0] ext_adr, ext_wdat;
  logic [3:0]  ext_sel;
  logic        ext_ack;
  logic [31:0] ext_rdat;
  logic        err_clr;
  logic        bus_err;
  logic [31:0] err_adr;

  cpu_bus_bridge #(.TIMEOUT_CYCLES(T), .BAD_DATA(BAD)) dut (
    .sys_clk(sys_clk), .i_reset(i_reset),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_wdat(cpu_wdat), .cpu_sel(cpu_sel), .cpu_ack(cpu_ack), .cpu_rdat(cpu_rdat),
    .madam_rd(madam_rd), .madam_wr(madam_wr), .madam_rdat(madam_rdat),
    .clio_rd(clio_rd), .clio_wr(clio_wr), .clio_rdat(clio_rdat),
    .reg_adr(reg_adr), .reg_wdat(reg_wdat),
    .ext_stb(ext_stb), .ext_adr(ext_adr), .ext_we(ext_we), .ext_sel(ext_sel),
    .ext_wdat(ext_wdat), .ext_ack(ext_ack), .ext_rdat(ext_rdat),
    .err_clr(err_clr), .bus_err(bus_err), .err_adr(err_adr)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, produced by the model below.
  bit          chk_en = 0;
  logic        e_ack, e_rchk, e_mrd, e_mwr, e_crd, e_cwr, e_xstb, e_berr, e_we;
  logic [31:0] e_rdat, e_eadr, e_adr, e_wdat;
  logic [3:0]  e_sel;

  // Model-level error state and the address of the request in flight.
  logic        m_berr = 1'b0;
  logic [31:0] m_eadr = '0;
  logic [31:0] cur_adr;
  bit          clr_rand = 0;
  logic        clr_val  = 1'b0;
  bit          clr_at_tmo = 0;

  // Observations of the DUT, used by the hand-computed checks.
  int          n_ack = 0, n_xstb = 0, n_mrd = 0, n_mwr = 0, n_crd = 0, n_cwr = 0;
  logic [31:0] last_rdat = '0;

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("cpu_ack",  32'(cpu_ack),  32'(e_ack));
      chk("madam_rd", 32'(madam_rd), 32'(e_mrd));
      chk("madam_wr", 32'(madam_wr), 32'(e_mwr));
      chk("clio_rd",  32'(clio_rd),  32'(e_crd));
      chk("clio_wr",  32'(clio_wr),  32'(e_cwr));
      chk("ext_stb",  32'(ext_stb),  32'(e_xstb));
      chk("bus_err",  32'(bus_err),  32'(e_berr));
      chk("err_adr",  err_adr,       e_eadr);
      if (e_ack && e_rchk) chk("cpu_rdat", cpu_rdat, e_rdat);
      if (e_mrd || e_mwr || e_crd || e_cwr) begin
        chk("reg_adr",  reg_adr,  e_adr);
        chk("reg_wdat", reg_wdat, e_wdat);
      end
      if (e_xstb) begin
        chk("ext_adr",  ext_adr,        e_adr);
        chk("ext_we",   32'(ext_we),    32'(e_we));
        chk("ext_sel",  32'(ext_sel),   32'(e_sel));
        chk("ext_wdat", ext_wdat,       e_wdat);
      end
      if (cpu_ack) begin n_ack++; last_rdat = cpu_rdat; end
      if (ext_stb)  n_xstb++;
      if (madam_rd) n_mrd++;
      if (madam_wr) n_mwr++;
      if (clio_rd)  n_crd++;
      if (clio_wr)  n_cwr++;
    end
  end

  // 0 = external, 1 = SVF, 2 = MADAM, 3 = CLIO (each window is 64 KiB).
  function automatic int region_of(input logic [31:0] a);
    if (a >= 32'h0320_0000 && a < 32'h0321_0000) return 1;
    if (a >= 32'h0330_0000 && a < 32'h0331_0000) return 2;
    if (a >= 32'h0340_0000 && a < 32'h0341_0000) return 3;
    return 0;
  endfunction

  task automatic set_idle();
    e_ack = 0; e_rchk = 0; e_mrd = 0; e_mwr = 0; e_crd = 0; e_cwr = 0; e_xstb = 0;
  endtask

  // Random slave-side values; the DUT must ignore them outside their waiting states.
  task automatic noise();
    madam_rdat = $urandom; clio_rdat = $urandom; ext_rdat = $urandom;
    ext_ack = 1'($urandom_range(0, 1));
  endtask

  // One clock: publish expectations for this cycle, then advance the error model across the edge.
  task automatic cyc_step(input bit tmo, input bit rst);
    err_clr = clr_rand ? ($urandom_range(0, 7) == 0) : clr_val;
    if (tmo && clr_at_tmo) err_clr = 1'b1;
    e_berr = m_berr;
    e_eadr = m_eadr;
    if (rst) begin
      m_berr = 0; m_eadr = '0;
    end else if (tmo) begin
      if (!m_berr) m_eadr = cur_adr;
      m_berr = 1;
    end else if (err_clr) begin
      m_berr = 0;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ack_force);
    for (int i = 0; i < n; i++) begin
      noise();
      if (ack_force) ext_ack = 1'b1;
      cpu_cyc = 0; cpu_stb = 0;
      set_idle();
      cyc_step(0, 0);
    end
  endtask

  // ack_dly: wait cycle on which ext_ack arrives (0 = never); abort_at/rst_at: wait cycle to drop cyc / reset.
  task automatic txn(input logic [31:0] adr, input bit we, input logic [31:0] wdat, input logic [3:0] sel,
                     input int ack_dly, input int abort_at, input int rst_at, input logic [31:0] val, input int gap);
    int rg, lim;
    bit ok, did_rst;
    rg = region_of(adr);
    cur_adr = adr;
    ok = 1; did_rst = 0;
    noise();
    cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_adr = adr; cpu_wdat = wdat; cpu_sel = sel;
    set_idle();
    cyc_step(0, 0);
    set_idle();
    e_adr = adr; e_wdat = wdat; e_we = we; e_sel = sel;
    if (rg == 1) begin
      noise();
      e_ack = 1; e_rdat = BAD; e_rchk = !we;
      cyc_step(0, 0);
    end else if (rg == 2 || rg == 3) begin
      noise();
      if (rg == 2) begin madam_rdat = val; e_mrd = !we; e_mwr = we; end
      else         begin clio_rdat  = val; e_crd = !we; e_cwr = we; end
      if (abort_at == 1) begin cpu_cyc = 0; cpu_stb = 0; ok = 0; end
      cyc_step(0, 0);
      set_idle();
      if (ok) begin
        noise();
        e_ack = 1; e_rdat = we ? 32'h0 : val; e_rchk = 1;
        cyc_step(0, 0);
      end
    end else begin
      lim = (ack_dly >= 1 && ack_dly <= T) ? ack_dly : T;
      for (int k = 1; k <= lim && ok; k++) begin
        noise();
        ext_ack = (k == ack_dly);
        if (k == ack_dly) ext_rdat = val;
        e_xstb = 1;
        if (abort_at == k) begin cpu_cyc = 0; cpu_stb = 0; ok = 0; end
        if (rst_at == k) begin i_reset = 1; ok = 0; did_rst = 1; end
        cyc_step(ok && k == lim && ack_dly != k, rst_at == k);
      end
      set_idle();
      if (did_rst) begin
        chk("rst_ext_stb",  32'(ext_stb), 32'h0);
        chk("rst_cpu_ack",  32'(cpu_ack), 32'h0);
        chk("rst_bus_err",  32'(bus_err), 32'h0);
        chk("rst_err_adr",  err_adr,      32'h0);
        chk("rst_cpu_rdat", cpu_rdat,     32'h0);
        i_reset = 0;
      end
      if (ok) begin
        noise();
        e_ack = 1; e_rchk = 1;
        e_rdat = (ack_dly >= 1 && ack_dly <= T) ? val : BAD;
        cyc_step(0, 0);
      end
    end
    idle(gap, 0);
  endtask

  logic [31:0] edges [8] = '{32'h031F_FFFF, 32'h0321_0000, 32'h032F_FFFF, 32'h0330_FFFF,
                             32'h0331_0000, 32'h0340_FFFF, 32'h0341_0000, 32'h0320_0000};

  initial begin
    int s_mrd, s_cwr, s_ack, s_x, s_all;
    logic [31:0] a;
    i_reset = 1; cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_adr = '0; cpu_wdat = '0; cpu_sel = '0;
    madam_rdat = '0; clio_rdat = '0; ext_ack = 0; ext_rdat = '0; err_clr = 0;
    set_idle(); e_berr = 0; e_eadr = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_cpu_ack",  32'(cpu_ack), 32'h0);
    chk("reset_ext_stb",  32'(ext_stb), 32'h0);
    chk("reset_bus_err",  32'(bus_err), 32'h0);
    chk("reset_cpu_rdat", cpu_rdat,     32'h0);
    chk("reset_err_adr",  err_adr,      32'h0);
    chk("reset_strobes",  32'({madam_rd, madam_wr, clio_rd, clio_wr}), 32'h0);
    i_reset = 0;
    chk_en = 1;
    idle(2, 1);

    // MADAM read
    s_mrd = n_mrd;
    txn(32'h0330_0004, 0, 32'h0, 4'hF, 0, 0, 0, 32'h1234_5678, 1);
    chk("madam_rd_pulses", 32'(n_mrd - s_mrd), 32'd1);
    chk("madam_rd_data", last_rdat, 32'h1234_5678);

    // CLIO write
    s_cwr = n_cwr;
    txn(32'h0340_0010, 1, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 32'h0, 1);
    chk("clio_wr_pulses", 32'(n_cwr - s_cwr), 32'd1);
    chk("clio_wr_wdat", reg_wdat, 32'hA5A5_A5A5);

    // SVF read: immediate BAD_DATA, no strobes
    s_all = n_mrd + n_mwr + n_crd + n_cwr + n_xstb;
    txn(32'h0320_0000, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 1);
    chk("svf_no_strobe", 32'(n_mrd + n_mwr + n_crd + n_cwr + n_xstb - s_all), 32'd0);
    chk("svf_rdat", last_rdat, 32'hBADA_CCE5);

    // External read completing on the 5th wait cycle
    s_x = n_xstb;
    txn(32'h0000_0100, 0, 32'h0, 4'hF, 5, 0, 0, 32'hE1A0_0000, 1);
    chk("ext_stb_cycles", 32'(n_xstb - s_x), 32'd5);
    chk("ext_rdat", last_rdat, 32'hE1A0_0000);

    // Timeouts, sticky err_adr, clear
    s_x = n_xstb;
    txn(32'h0020_0000, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 1);
    chk("tmo_stb_cycles", 32'(n_xstb - s_x), 32'd8);
    chk("tmo_rdat", last_rdat, 32'hBADA_CCE5);
    chk("tmo_bus_err", 32'(bus_err), 32'h1);
    chk("tmo_err_adr", err_adr, 32'h0020_0000);
    txn(32'h0030_0000, 1, 32'h1111_2222, 4'h3, 0, 0, 0, 32'h0, 1);
    chk("tmo2_err_adr", err_adr, 32'h0020_0000);
    clr_val = 1; idle(1, 0); clr_val = 0;
    chk("clr_bus_err", 32'(bus_err), 32'h0);

    // Clear in the same cycle as a timeout: set wins
    clr_at_tmo = 1;
    txn(32'h0040_0000, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 0);
    clr_at_tmo = 0;
    chk("clr_vs_tmo_err", 32'(bus_err), 32'h1);
    chk("clr_vs_tmo_adr", err_adr, 32'h0040_0000);
    clr_val = 1; idle(1, 0); clr_val = 0;

    // ext_ack on the timeout cycle: ack wins, no error
    txn(32'h0050_0000, 0, 32'h0, 4'hF, T, 0, 0, 32'hCAFE_F00D, 1);
    chk("ack_vs_tmo_rdat", last_rdat, 32'hCAFE_F00D);
    chk("ack_vs_tmo_err", 32'(bus_err), 32'h0);

    // Aborts: register strobe not retracted, no ack
    s_mrd = n_mrd; s_ack = n_ack;
    txn(32'h0330_0008, 0, 32'h0, 4'hF, 0, 1, 0, 32'h0, 1);
    txn(32'h0060_0000, 0, 32'h0, 4'hF, 0, 2, 0, 32'h0, 1);
    chk("abort_strobe", 32'(n_mrd - s_mrd), 32'd1);
    chk("abort_no_ack", 32'(n_ack - s_ack), 32'd0);

    // Reset in the middle of an external wait, then a stray ext_ack
    s_ack = n_ack;
    txn(32'h0070_0000, 0, 32'h0, 4'hF, 0, 0, 3, 32'h0, 0);
    idle(2, 1);
    chk("rst_stray_ack", 32'(n_ack - s_ack), 32'd0);

    // Back-to-back requests with cyc/stb held through the ack cycle
    txn(32'h0340_0020, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0BAD_F00D, 0);
    txn(32'h0340_0024, 1, 32'h5A5A_0000, 4'h1, 0, 0, 0, 32'h0, 0);
    txn(32'h0000_0200, 0, 32'h0, 4'hF, 2, 0, 0, 32'h7777_8888, 1);

    // Randomized traffic
    clr_rand = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h0320_0000 | 32'($urandom_range(0, 16'hFFFF));
        1:       a = 32'h0330_0000 | 32'($urandom_range(0, 16'hFFFF));
        2:       a = 32'h0340_0000 | 32'($urandom_range(0, 16'hFFFF));
        3:       a = edges[$urandom_range(0, 7)];
        4:       a = 32'($urandom_range(0, 32'h00FF_FFFF));
        default: a = $urandom;
      endcase
      txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 11),
          ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0,
          ($urandom_range(0, 39) == 0) ? $urandom_range(1, 3) : 0,
          $urandom, $urandom_range(0, 2));
    end
    clr_rand = 0;
    idle(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
